mem_wb_stage: RTL and testbench
===============================

// Module: mem_wb_stage
// PURPOSE
//  MEM/WB pipeline register plus writeback select for the 5-stage MIPS core.
//  Captures the MEM-stage result and aligns/extends load data. Picks the
//  ALU, load or link value and drives registerfile write port
//  (Write_Reg_Num, Write_Data, RegWrite_mm_wb).
//  Holds the pipeline while a data-memory load is outstanding, with timeout.
// PARAMETERS
//  MEM_TIMEOUT  15  max cycles waiting for mem_ack before load aborts (1..255)
// PORTS
//  clk              in   1   rising-edge clock
//  reset            in   1   async, active-low; 0 = reset
//  stall            in   1   hold WB register (downstream/hazard stall)
//  flush            in   1   replace next WB entry with bubble
//  valid_mm         in   1   MEM stage holds a real instruction
//  RegWrite_mm      in   1   instruction writes a register
//  MemtoReg_mm      in   1   instruction is a load (result = memory data)
//  Link_mm          in   1   JAL/JALR: result = PC_plus8_mm
//  LoadType_mm      in   3   000 LW, 001 LB, 010 LBU, 011 LH, 100 LHU
//  Write_Reg_Num_mm in   5   destination register
//  ALU_Result_mm    in   32  ALU result / load address
//  PC_plus8_mm      in   32  link value
//  Mem_Read_Data    in   32  data-memory read word (word-aligned)
//  mem_ack          in   1   Mem_Read_Data valid this cycle
//  stall_req        out  1   MEM must hold (load waiting); combinational
//  Write_Reg_Num    out  5   registerfile write address
//  Write_Data       out  32  registerfile write data
//  RegWrite_mm_wb   out  1   registerfile write enable
//  valid_wb         out  1   WB holds a real instruction
//  addr_err_wb      out  1   misaligned load/unknown LoadType captured, write dropped
//  bus_err_wb       out  1   load timed out, write dropped
// BEHAVIOUR
//  Reset (reset==0, async): all outputs 0, FSM=RUN, wait_cnt=0.
//  FSM RUN: load_pend = valid_mm & MemtoReg_mm & ~mem_ack.
//   load_pend & ~flush -> stall_req=1. Goes to WAIT at the edge unless stall.
//   WB gets a bubble at that edge (unless stall: hold).
//  FSM WAIT: stall_req=1 while ~mem_ack. wait_cnt increments each cycle.
//   On mem_ack: capture load, go to RUN, clear wait_cnt.
//   wait_cnt==MEM_TIMEOUT-1 w/o ack: capture bubble with bus_err_wb=1,
//   stall_req=0 that cycle, go to RUN.
//   flush in WAIT: abort, go to RUN, bubble captured.
//  Capture priority per edge: flush > stall > load_pend bubble > normal.
//   flush: valid_wb=0, RegWrite_mm_wb=0, errors 0; other outputs don't care.
//   stall: every output register holds; FSM and wait_cnt hold.
//    In WAIT, mem_ack during stall does not complete the load.
//   normal: latency 1 cycle, MEM inputs -> WB outputs at next edge.
//  Write data select: Link_mm ? PC_plus8_mm : MemtoReg_mm ? load_val : ALU_Result_mm.
//  load_val, big-endian, a=ALU_Result_mm[1:0]:
//   byte k = Mem_Read_Data[31-8k -: 8]; half h = Mem_Read_Data[31-16h -: 16].
//   LW needs a==0; LH/LHU need a[0]==0; LB/LBU any a.
//   LB/LH sign-extend to 32; LBU/LHU zero-extend.
//   Misaligned or LoadType 101..111: addr_err_wb=1, RegWrite_mm_wb=0, valid_wb=1.
//  RegWrite_mm_wb = valid_mm & RegWrite_mm & no error & (Write_Reg_Num_mm!=0).
//   Writes to $0 are always suppressed.
//  Error flags are single-entry: cleared by the next non-stalled capture.
//  valid_mm=0: bubble regardless of other controls.
// TESTING
//  1 ALU op: Write_Reg_Num_mm=5, ALU_Result_mm=0x1234, RegWrite_mm=1
//    -> next edge Write_Data=0x1234, RegWrite_mm_wb=1.
//  2 LB a=2, Mem_Read_Data=0x1122F344, mem_ack=1
//    -> Write_Data=0xFFFFFFF3. LHU a=2 -> 0x0000F344.
//  3 LH a=1 -> addr_err_wb=1, RegWrite_mm_wb=0.
//    Write to reg 0 with RegWrite_mm=1 -> RegWrite_mm_wb=0.
//  4 Load, mem_ack low 3 cycles then high -> stall_req high 3 cycles, bubbles meanwhile.
//    4th edge captures data, FSM=RUN.
//  5 Load, mem_ack never -> after MEM_TIMEOUT=15 cycles: bus_err_wb=1,
//    stall_req=0, RegWrite_mm_wb=0.
//  6 stall&flush same cycle -> bubble. stall alone 2 cycles -> outputs held.
//    reset low mid-WAIT -> outputs 0 immediately, FSM=RUN.

Source files
------------

// File: rtl/mem_wb_stage.sv
// -----------------------------------------------------------------------------
// mem_wb_stage
//   MEM/WB pipeline register and writeback select for the 5-stage MIPS core.
//   Captures the MEM-stage result, aligns and extends big-endian load data, and
//   picks the link, load or ALU value for the register-file write port.
//   While a data-memory load has not yet been acknowledged, the stage raises
//   stall_req so MEM holds. It inserts bubbles into WB and gives up after
//   MEM_TIMEOUT cycles, flagging a bus error.
//
// Handshake: the memory delivers Mem_Read_Data in the cycle it raises mem_ack.
//   A load completes only in a cycle where mem_ack=1 and stall=0. While
//   stall_req=1, MEM must present the same instruction again in the next cycle.
//
// Ports
//   clk, reset               rising-edge clock, async active-low reset
//   stall, flush             hold WB register / force a bubble into WB
//   valid_mm .. PC_plus8_mm  MEM-stage instruction fields
//   Mem_Read_Data, mem_ack   data-memory read word and its valid strobe
//   stall_req                combinational request for MEM to hold
//   Write_Reg_Num/Write_Data/RegWrite_mm_wb  register-file write port
//   valid_wb                 WB holds a real instruction
//   addr_err_wb, bus_err_wb  misaligned/unknown load, load timeout
//   state_dbg, wait_cnt_dbg  FSM state (0 RUN, 1 WAIT) and wait counter
// -----------------------------------------------------------------------------
module mem_wb_stage #(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic        valid_mm,
  input  logic        RegWrite_mm,
  input  logic        MemtoReg_mm,
  input  logic        Link_mm,
  input  logic [2:0]  LoadType_mm,
  input  logic [4:0]  Write_Reg_Num_mm,
  input  logic [31:0] ALU_Result_mm,
  input  logic [31:0] PC_plus8_mm,
  input  logic [31:0] Mem_Read_Data,
  input  logic        mem_ack,
  output logic        stall_req,
  output logic [4:0]  Write_Reg_Num,
  output logic [31:0] Write_Data,
  output logic        RegWrite_mm_wb,
  output logic        valid_wb,
  output logic        addr_err_wb,
  output logic        bus_err_wb,
  output logic        state_dbg,
  output logic [7:0]  wait_cnt_dbg
);

  typedef enum logic {S_RUN = 1'b0, S_WAIT = 1'b1} state_t;

  localparam logic [7:0] TIMEOUT_LAST = 8'(MEM_TIMEOUT - 1);

  state_t     state;
  logic [7:0] wait_cnt;

  logic [1:0]  a;
  logic [7:0]  sel_byte;
  logic [15:0] sel_half;
  logic [31:0] load_val;
  logic        load_err;
  logic        addr_err_next;
  logic        regwrite_next;
  logic [31:0] wb_data_next;
  logic        load_pend;
  logic        timeout_hit;

  assign a = ALU_Result_mm[1:0];

  // Big-endian lane select: byte 0 is the most significant byte of the word.
  always_comb begin
    sel_byte = Mem_Read_Data[31:24];
    case (a)
      2'd0: sel_byte = Mem_Read_Data[31:24];
      2'd1: sel_byte = Mem_Read_Data[23:16];
      2'd2: sel_byte = Mem_Read_Data[15:8];
      2'd3: sel_byte = Mem_Read_Data[7:0];
      default: sel_byte = Mem_Read_Data[31:24];
    endcase
    sel_half = a[1] ? Mem_Read_Data[15:0] : Mem_Read_Data[31:16];
  end

  always_comb begin
    load_val = Mem_Read_Data;
    load_err = 1'b0;
    case (LoadType_mm)
      3'b000: begin load_val = Mem_Read_Data;                    load_err = (a != 2'd0); end
      3'b001: begin load_val = {{24{sel_byte[7]}}, sel_byte};    load_err = 1'b0;        end
      3'b010: begin load_val = {24'd0, sel_byte};                load_err = 1'b0;        end
      3'b011: begin load_val = {{16{sel_half[15]}}, sel_half};   load_err = a[0];        end
      3'b100: begin load_val = {16'd0, sel_half};                load_err = a[0];        end
      default: begin load_val = Mem_Read_Data;                   load_err = 1'b1;        end
    endcase
  end

  // A link instruction never consumes load data, so only real loads can fault.
  assign addr_err_next = valid_mm & MemtoReg_mm & ~Link_mm & load_err;
  assign regwrite_next = valid_mm & RegWrite_mm & ~addr_err_next &
                         (Write_Reg_Num_mm != 5'd0);
  assign wb_data_next  = Link_mm     ? PC_plus8_mm :
                         MemtoReg_mm ? load_val    : ALU_Result_mm;

  assign load_pend   = valid_mm & MemtoReg_mm & ~mem_ack;
  // Timeout only fires on an edge that actually advances the FSM.
  assign timeout_hit = (state == S_WAIT) & ~mem_ack & ~flush & ~stall &
                       (wait_cnt == TIMEOUT_LAST);

  always_comb begin
    stall_req = 1'b0;
    if (reset && !flush) begin
      if (state == S_RUN) stall_req = load_pend;
      else                stall_req = ~mem_ack & ~timeout_hit;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= S_RUN;
      wait_cnt       <= 8'd0;
      Write_Reg_Num  <= 5'd0;
      Write_Data     <= 32'd0;
      RegWrite_mm_wb <= 1'b0;
      valid_wb       <= 1'b0;
      addr_err_wb    <= 1'b0;
      bus_err_wb     <= 1'b0;
    end else if (flush) begin
      state          <= S_RUN;
      wait_cnt       <= 8'd0;
      RegWrite_mm_wb <= 1'b0;
      valid_wb       <= 1'b0;
      addr_err_wb    <= 1'b0;
      bus_err_wb     <= 1'b0;
    end else if (!stall) begin
      if ((state == S_RUN && !load_pend) || (state == S_WAIT && mem_ack)) begin
        // Normal capture (also completes an acknowledged load in WAIT).
        state          <= S_RUN;
        wait_cnt       <= 8'd0;
        Write_Reg_Num  <= Write_Reg_Num_mm;
        Write_Data     <= wb_data_next;
        RegWrite_mm_wb <= regwrite_next;
        valid_wb       <= valid_mm;
        addr_err_wb    <= addr_err_next;
        bus_err_wb     <= 1'b0;
      end else begin
        // Load not yet acknowledged: WB receives a bubble.
        RegWrite_mm_wb <= 1'b0;
        valid_wb       <= 1'b0;
        addr_err_wb    <= 1'b0;
        if (state == S_RUN) begin
          state      <= S_WAIT;
          wait_cnt   <= 8'd0;
          bus_err_wb <= 1'b0;
        end else if (wait_cnt == TIMEOUT_LAST) begin
          state      <= S_RUN;
          wait_cnt   <= 8'd0;
          bus_err_wb <= 1'b1;
        end else begin
          wait_cnt   <= wait_cnt + 8'd1;
          bus_err_wb <= 1'b0;
        end
      end
    end
  end

  assign state_dbg    = state;
  assign wait_cnt_dbg = wait_cnt;

endmodule

// File: tb/tb_mem_wb_stage.sv
module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall, flush, valid_mm, RegWrite_mm, MemtoReg_mm, Link_mm;
  logic [2:0]  LoadType_mm;
  logic [4:0]  Write_Reg_Num_mm;
  logic [31:0] ALU_Result_mm, PC_plus8_mm, Mem_Read_Data;
  logic        mem_ack;
  logic        stall_req;
  logic [4:0]  Write_Reg_Num;
  logic [31:0] Write_Data;
  logic        RegWrite_mm_wb, valid_wb, addr_err_wb, bus_err_wb, state_dbg;
  logic [7:0]  wait_cnt_dbg;

  int n_cmp = 0;
  int n_err = 0;

  mem_wb_stage #(.MEM_TIMEOUT(15)) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .valid_mm(valid_mm), .RegWrite_mm(RegWrite_mm), .MemtoReg_mm(MemtoReg_mm),
    .Link_mm(Link_mm), .LoadType_mm(LoadType_mm), .Write_Reg_Num_mm(Write_Reg_Num_mm),
    .ALU_Result_mm(ALU_Result_mm), .PC_plus8_mm(PC_plus8_mm),
    .Mem_Read_Data(Mem_Read_Data), .mem_ack(mem_ack), .stall_req(stall_req),
    .Write_Reg_Num(Write_Reg_Num), .Write_Data(Write_Data),
    .RegWrite_mm_wb(RegWrite_mm_wb), .valid_wb(valid_wb),
    .addr_err_wb(addr_err_wb), .bus_err_wb(bus_err_wb),
    .state_dbg(state_dbg), .wait_cnt_dbg(wait_cnt_dbg)
  );

  // Clock / reset
  always #5 clk = ~clk;

  // Comparison point
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Driver tasks
  task automatic drv_idle();
    stall = 0; flush = 0; valid_mm = 0; RegWrite_mm = 0; MemtoReg_mm = 0;
    Link_mm = 0; LoadType_mm = 3'b000; Write_Reg_Num_mm = 5'd0;
    ALU_Result_mm = 32'd0; PC_plus8_mm = 32'd0; Mem_Read_Data = 32'd0; mem_ack = 0;
  endtask

  task automatic drv_alu(input logic [4:0] rd, input logic [31:0] val, input logic rw);
    drv_idle();
    valid_mm = 1; RegWrite_mm = rw; Write_Reg_Num_mm = rd; ALU_Result_mm = val;
  endtask

  task automatic drv_load(input logic [2:0] lt, input logic [4:0] rd,
                          input logic [31:0] addr, input logic [31:0] data,
                          input logic ack);
    drv_idle();
    valid_mm = 1; RegWrite_mm = 1; MemtoReg_mm = 1; LoadType_mm = lt;
    Write_Reg_Num_mm = rd; ALU_Result_mm = addr; Mem_Read_Data = data; mem_ack = ack;
  endtask

  task automatic chk_wb(input string tag, input logic [31:0] wd, input logic rw,
                        input logic v, input logic ae, input logic be);
    chk({tag, "_data"}, Write_Data, wd);
    chk({tag, "_rw"}, {31'd0, RegWrite_mm_wb}, {31'd0, rw});
    chk({tag, "_valid"}, {31'd0, valid_wb}, {31'd0, v});
    chk({tag, "_aerr"}, {31'd0, addr_err_wb}, {31'd0, ae});
    chk({tag, "_berr"}, {31'd0, bus_err_wb}, {31'd0, be});
  endtask

  task automatic chk_ctl(input string tag, input logic rw, input logic v,
                         input logic ae, input logic be);
    chk({tag, "_rw"}, {31'd0, RegWrite_mm_wb}, {31'd0, rw});
    chk({tag, "_valid"}, {31'd0, valid_wb}, {31'd0, v});
    chk({tag, "_aerr"}, {31'd0, addr_err_wb}, {31'd0, ae});
    chk({tag, "_berr"}, {31'd0, bus_err_wb}, {31'd0, be});
  endtask

  initial begin
    drv_idle();
    reset = 0;
    #3;
    chk_wb("rst", 32'd0, 0, 0, 0, 0);
    chk("rst_rd", {27'd0, Write_Reg_Num}, 32'd0);
    chk("rst_state", {31'd0, state_dbg}, 32'd0);
    chk("rst_sreq", {31'd0, stall_req}, 32'd0);
    @(negedge clk); @(negedge clk);
    reset = 1;

    // 1: ALU op
    drv_alu(5'd5, 32'h0000_1234, 1);
    tick();
    chk_wb("alu", 32'h0000_1234, 1, 1, 0, 0);
    chk("alu_rd", {27'd0, Write_Reg_Num}, 32'd5);

    // 2: load extraction
    drv_load(3'b001, 5'd6, 32'h0000_0102, 32'h1122_F344, 1);
    #1 chk("lb_sreq", {31'd0, stall_req}, 32'd0);
    tick();
    chk_wb("lb_a2", 32'hFFFF_FFF3, 1, 1, 0, 0);
    drv_load(3'b100, 5'd6, 32'h0000_0102, 32'h1122_F344, 1);
    tick();
    chk_wb("lhu_a2", 32'h0000_F344, 1, 1, 0, 0);
    drv_load(3'b000, 5'd7, 32'h0000_0100, 32'hDEAD_BEEF, 1);
    tick();
    chk_wb("lw_a0", 32'hDEAD_BEEF, 1, 1, 0, 0);
    drv_load(3'b010, 5'd7, 32'h0000_0100, 32'h9122_F344, 1);
    tick();
    chk_wb("lbu_a0", 32'h0000_0091, 1, 1, 0, 0);
    drv_load(3'b011, 5'd7, 32'h0000_0100, 32'h8001_0000, 1);
    tick();
    chk_wb("lh_a0", 32'hFFFF_8001, 1, 1, 0, 0);
    drv_alu(5'd31, 32'h0000_0055, 1);
    Link_mm = 1; PC_plus8_mm = 32'h0000_0400;
    tick();
    chk_wb("link", 32'h0000_0400, 1, 1, 0, 0);

    // 3: errors and $0
    drv_load(3'b011, 5'd8, 32'h0000_0101, 32'h1122_3344, 1);
    tick();
    chk_ctl("lh_a1", 0, 1, 1, 0);
    drv_load(3'b000, 5'd8, 32'h0000_0102, 32'h1122_3344, 1);
    tick();
    chk_ctl("lw_a2", 0, 1, 1, 0);
    drv_load(3'b101, 5'd8, 32'h0000_0100, 32'h1122_3344, 1);
    tick();
    chk_ctl("lt101", 0, 1, 1, 0);
    drv_alu(5'd0, 32'h0000_0077, 1);
    tick();
    chk_ctl("r0", 0, 1, 0, 0);

    // 4: load acknowledged after 3 cycles
    drv_load(3'b000, 5'd7, 32'h0000_0010, 32'hCAFE_F00D, 0);
    for (int i = 0; i < 3; i++) begin
      #1 chk("wait_sreq", {31'd0, stall_req}, 32'd1);
      tick();
      chk_ctl("wait_bub", 0, 0, 0, 0);
      chk("wait_state", {31'd0, state_dbg}, 32'd1);
    end
    mem_ack = 1;
    #1 chk("ack_sreq", {31'd0, stall_req}, 32'd0);
    tick();
    chk_wb("ack_cap", 32'hCAFE_F00D, 1, 1, 0, 0);
    chk("ack_state", {31'd0, state_dbg}, 32'd0);

    // 5: timeout
    drv_load(3'b000, 5'd8, 32'h0000_0020, 32'h0, 0);
    for (int i = 0; i < 15; i++) begin
      #1 chk("to_sreq", {31'd0, stall_req}, 32'd1);
      tick();
      chk_ctl("to_bub", 0, 0, 0, 0);
    end
    chk("to_cnt", {24'd0, wait_cnt_dbg}, 32'd14);
    #1 chk("to_sreq_last", {31'd0, stall_req}, 32'd0);
    tick();
    chk_ctl("to_berr", 0, 0, 0, 1);
    chk("to_state", {31'd0, state_dbg}, 32'd0);
    drv_idle();
    tick();
    chk_ctl("berr_clr", 0, 0, 0, 0);

    // 6: stall / flush
    drv_alu(5'd9, 32'h0000_AAAA, 1);
    tick();
    chk_wb("pre_sf", 32'h0000_AAAA, 1, 1, 0, 0);
    drv_alu(5'd10, 32'h0000_1010, 1);
    stall = 1; flush = 1;
    tick();
    chk_ctl("stall_flush", 0, 0, 0, 0);
    drv_alu(5'd11, 32'h0000_BBBB, 1);
    tick();
    chk_wb("pre_stall", 32'h0000_BBBB, 1, 1, 0, 0);
    drv_alu(5'd12, 32'h0000_CCCC, 1);
    stall = 1;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk_wb("stall_hold", 32'h0000_BBBB, 1, 1, 0, 0);
      chk("stall_rd", {27'd0, Write_Reg_Num}, 32'd11);
    end
    stall = 0;
    tick();
    chk_wb("unstall", 32'h0000_CCCC, 1, 1, 0, 0);

    // flush aborts a pending load
    drv_load(3'b000, 5'd13, 32'h0000_0030, 32'h1357_9BDF, 0);
    tick();
    chk("fw_state", {31'd0, state_dbg}, 32'd1);
    flush = 1;
    #1 chk("fw_sreq", {31'd0, stall_req}, 32'd0);
    tick();
    chk("fw_state2", {31'd0, state_dbg}, 32'd0);
    chk_ctl("fw_bub", 0, 0, 0, 0);

    // ack during stall does not complete the load
    drv_load(3'b000, 5'd13, 32'h0000_0030, 32'h1357_9BDF, 0);
    tick();
    mem_ack = 1; stall = 1;
    tick();
    chk("sw_state", {31'd0, state_dbg}, 32'd1);
    chk_ctl("sw_hold", 0, 0, 0, 0);
    stall = 0;
    tick();
    chk_wb("sw_cap", 32'h1357_9BDF, 1, 1, 0, 0);

    // reset in the middle of WAIT
    drv_load(3'b000, 5'd14, 32'h0000_0040, 32'h0, 0);
    tick();
    chk("rw_state", {31'd0, state_dbg}, 32'd1);
    #2 reset = 0;
    #1;
    chk_wb("rw", 32'd0, 0, 0, 0, 0);
    chk("rw_rd", {27'd0, Write_Reg_Num}, 32'd0);
    chk("rw_state2", {31'd0, state_dbg}, 32'd0);
    chk("rw_sreq", {31'd0, stall_req}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
